// File: rtl/multicycle_main_control_if.sv
// Control-unit bus: instruction/status inputs and datapath control outputs.
// The controller connects as master, and the environment connects as slave.
interface multicycle_main_control_if #(
   parameter int STATE_W = 4
);
   logic [5:0]         opcode;
   logic               zero;
   logic               mem_ready;
   logic [2:0]         ALUOp;
   logic               PCWrite;
   logic               IorD;
   logic               MemRead;
   logic               MemWrite;
   logic               IRWrite;
   logic               MemtoReg;
   logic               RegDst;
   logic               RegWrite;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic               ZeroExt;
   logic [1:0]         PCSource;
   logic               illegal_op;
   logic [STATE_W-1:0] dbg_state;

   modport master (
      input  opcode, zero, mem_ready,
      output ALUOp, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
             RegWrite, ALUSrcA, ALUSrcB, ZeroExt, PCSource, illegal_op, dbg_state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  ALUOp, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
             RegWrite, ALUSrcA, ALUSrcB, ZeroExt, PCSource, illegal_op, dbg_state
   );
endinterface

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS-subset main control: a state register with next-state logic,
// plus Moore decode of the datapath controls. Write/request strobes are gated by reset.
module multicycle_main_control #(
   parameter int STATE_W = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   multicycle_main_control_if.master     bus
);
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH     = STATE_W'(0),
      S_DECODE    = STATE_W'(1),
      S_MEM_ADDR  = STATE_W'(2),
      S_MEM_READ  = STATE_W'(3),
      S_MEM_WB    = STATE_W'(4),
      S_MEM_WRITE = STATE_W'(5),
      S_R_EXEC    = STATE_W'(6),
      S_R_WB      = STATE_W'(7),
      S_BRANCH    = STATE_W'(8),
      S_I_EXEC    = STATE_W'(9),
      S_I_WB      = STATE_W'(10),
      S_JUMP      = STATE_W'(11)
   } state_t;

   state_t r_state;
   logic   r_run;     // low from reset until the first clock after release
   logic   w_en;
   logic   w_pcw, w_mr, w_mw, w_irw, w_rw, w_ill;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_FETCH;
         r_run   <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (r_run) begin
            case (r_state)
               S_FETCH:     if (bus.mem_ready) r_state <= S_DECODE;
               S_DECODE: begin
                  case (bus.opcode)
                     OP_R:                   r_state <= S_R_EXEC;
                     OP_ADDI, OP_ORI, OP_LUI: r_state <= S_I_EXEC;
                     OP_LW, OP_SW:           r_state <= S_MEM_ADDR;
                     OP_BEQ, OP_BNE:         r_state <= S_BRANCH;
                     OP_J:                   r_state <= S_JUMP;
                     default:                r_state <= S_FETCH;
                  endcase
               end
               S_MEM_ADDR:  r_state <= (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
               S_MEM_READ:  if (bus.mem_ready) r_state <= S_MEM_WB;
               S_MEM_WRITE: if (bus.mem_ready) r_state <= S_FETCH;
               S_R_EXEC:    r_state <= S_R_WB;
               S_I_EXEC:    r_state <= S_I_WB;
               default:     r_state <= S_FETCH;
            endcase
         end
      end
   end

   assign w_en = reset & r_run;

   always_comb begin
      bus.ALUOp    = 3'b100;
      bus.IorD     = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.RegDst   = 1'b0;
      bus.ALUSrcA  = 1'b0;
      bus.ALUSrcB  = 2'b00;
      bus.ZeroExt  = 1'b0;
      bus.PCSource = 2'b00;
      w_pcw = 1'b0;
      w_mr  = 1'b0;
      w_mw  = 1'b0;
      w_irw = 1'b0;
      w_rw  = 1'b0;
      w_ill = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mr        = 1'b1;
            bus.ALUSrcB = 2'b01;
            w_irw       = bus.mem_ready;
            w_pcw       = bus.mem_ready;
         end
         S_DECODE: begin
            bus.ALUSrcB = 2'b11;
            case (bus.opcode)
               OP_R, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: w_ill = 1'b0;
               default: w_ill = 1'b1;
            endcase
         end
         S_MEM_ADDR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
         end
         S_MEM_READ: begin
            w_mr     = 1'b1;
            bus.IorD = 1'b1;
         end
         S_MEM_WB: begin
            w_rw         = 1'b1;
            bus.MemtoReg = 1'b1;
         end
         S_MEM_WRITE: begin
            w_mw     = 1'b1;
            bus.IorD = 1'b1;
         end
         S_R_EXEC: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = 3'b111;
         end
         S_R_WB: begin
            w_rw       = 1'b1;
            bus.RegDst = 1'b1;
         end
         S_BRANCH: begin
            bus.ALUSrcA  = 1'b1;
            bus.ALUOp    = 3'b110;
            bus.PCSource = 2'b01;
            w_pcw = ((bus.opcode == OP_BEQ) &  bus.zero) |
                    ((bus.opcode == OP_BNE) & ~bus.zero);
         end
         S_I_EXEC: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            case (bus.opcode)
               OP_ORI:  begin bus.ALUOp = 3'b101; bus.ZeroExt = 1'b1; end
               OP_LUI:  bus.ALUOp = 3'b000;
               default: bus.ALUOp = 3'b100;
            endcase
         end
         S_I_WB:      w_rw = 1'b1;
         S_JUMP: begin
            w_pcw        = 1'b1;
            bus.PCSource = 2'b10;
         end
         default: ;
      endcase
   end

   // Strobes drop combinationally with reset so an in-flight write aborts at once.
   assign bus.PCWrite    = w_pcw & w_en;
   assign bus.MemRead    = w_mr  & w_en;
   assign bus.MemWrite   = w_mw  & w_en;
   assign bus.IRWrite    = w_irw & w_en;
   assign bus.RegWrite   = w_rw  & w_en;
   assign bus.illegal_op = w_ill & w_en;
   assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed-vector bench: stimulus queues hand-written expected control words and
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_main_control;
   typedef struct packed {
      logic [3:0] st;
      logic [2:0] aluop;
      logic       pcw, iord, mr, mw, irw, m2r, rdst, rw, srca;
      logic [1:0] srcb;
      logic       zext;
      logic [1:0] pcsrc;
      logic       ill;
   } exp_t;

   localparam exp_t RST     = '{st:4'd0,  aluop:3'b100, srcb:2'b01, default:'0};
   localparam exp_t F_WAIT  = '{st:4'd0,  aluop:3'b100, mr:1'b1, srcb:2'b01, default:'0};
   localparam exp_t F_RDY   = '{st:4'd0,  aluop:3'b100, mr:1'b1, irw:1'b1, pcw:1'b1, srcb:2'b01, default:'0};
   localparam exp_t DEC     = '{st:4'd1,  aluop:3'b100, srcb:2'b11, default:'0};
   localparam exp_t DEC_ILL = '{st:4'd1,  aluop:3'b100, srcb:2'b11, ill:1'b1, default:'0};
   localparam exp_t MADDR   = '{st:4'd2,  aluop:3'b100, srca:1'b1, srcb:2'b10, default:'0};
   localparam exp_t MRD     = '{st:4'd3,  aluop:3'b100, mr:1'b1, iord:1'b1, default:'0};
   localparam exp_t MWB     = '{st:4'd4,  aluop:3'b100, rw:1'b1, m2r:1'b1, default:'0};
   localparam exp_t MWR     = '{st:4'd5,  aluop:3'b100, mw:1'b1, iord:1'b1, default:'0};
   localparam exp_t R_EX    = '{st:4'd6,  aluop:3'b111, srca:1'b1, default:'0};
   localparam exp_t R_WB    = '{st:4'd7,  aluop:3'b100, rw:1'b1, rdst:1'b1, default:'0};
   localparam exp_t BR_T    = '{st:4'd8,  aluop:3'b110, srca:1'b1, pcsrc:2'b01, pcw:1'b1, default:'0};
   localparam exp_t BR_N    = '{st:4'd8,  aluop:3'b110, srca:1'b1, pcsrc:2'b01, default:'0};
   localparam exp_t IEX_ADD = '{st:4'd9,  aluop:3'b100, srca:1'b1, srcb:2'b10, default:'0};
   localparam exp_t IEX_ORI = '{st:4'd9,  aluop:3'b101, srca:1'b1, srcb:2'b10, zext:1'b1, default:'0};
   localparam exp_t IEX_LUI = '{st:4'd9,  aluop:3'b000, srca:1'b1, srcb:2'b10, default:'0};
   localparam exp_t IWB     = '{st:4'd10, aluop:3'b100, rw:1'b1, default:'0};
   localparam exp_t JMP     = '{st:4'd11, aluop:3'b100, pcw:1'b1, pcsrc:2'b10, default:'0};

   localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, ORI = 6'b001101, LUI = 6'b001111;
   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
   localparam logic [5:0] J = 6'b000010, BAD = 6'b111111;

   logic clk = 1'b0;
   logic reset = 1'b0;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   multicycle_main_control_if #(.STATE_W(4)) bus();
   multicycle_main_control #(.STATE_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // Drive one cycle's inputs just after the rising edge and queue that cycle's expectation.
   task automatic cyc(input logic [5:0] op, input logic z, input logic rdy,
                      input logic rst, input exp_t e);
      @(posedge clk);
      #1;
      bus.opcode    = op;
      bus.zero      = z;
      bus.mem_ready = rdy;
      reset         = rst;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e, a;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            a = '{st:bus.dbg_state, aluop:bus.ALUOp, pcw:bus.PCWrite, iord:bus.IorD,
                  mr:bus.MemRead, mw:bus.MemWrite, irw:bus.IRWrite, m2r:bus.MemtoReg,
                  rdst:bus.RegDst, rw:bus.RegWrite, srca:bus.ALUSrcA, srcb:bus.ALUSrcB,
                  zext:bus.ZeroExt, pcsrc:bus.PCSource, ill:bus.illegal_op};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL step%0d t=%0t got=%h want=%h (st %0d/%0d aluop %b/%b)",
                        checks, $time, a, e, a.st, e.st, a.aluop, e.aluop);
            end
         end
      end
   end

   initial begin : stim
      bus.opcode = R; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      cyc(R, 0, 1, 0, RST);
      cyc(R, 0, 1, 0, RST);
      cyc(R, 0, 1, 1, RST);        // release cycle: strobes still held off
      // R-type
      cyc(R, 0, 1, 1, F_RDY);  cyc(R, 0, 1, 1, DEC);
      cyc(R, 0, 1, 1, R_EX);   cyc(R, 0, 1, 1, R_WB);
      // LW with memory wait states
      cyc(LW, 0, 0, 1, F_WAIT); cyc(LW, 0, 0, 1, F_WAIT); cyc(LW, 0, 1, 1, F_RDY);
      cyc(LW, 0, 1, 1, DEC);    cyc(LW, 0, 1, 1, MADDR);
      cyc(LW, 0, 0, 1, MRD);    cyc(LW, 0, 0, 1, MRD);    cyc(LW, 0, 0, 1, MRD);
      cyc(LW, 0, 1, 1, MRD);    cyc(LW, 0, 1, 1, MWB);
      // branches
      cyc(BEQ, 1, 1, 1, F_RDY); cyc(BEQ, 1, 1, 1, DEC); cyc(BEQ, 1, 1, 1, BR_T);
      cyc(BNE, 1, 1, 1, F_RDY); cyc(BNE, 1, 1, 1, DEC); cyc(BNE, 1, 1, 1, BR_N);
      cyc(BNE, 0, 1, 1, F_RDY); cyc(BNE, 0, 1, 1, DEC); cyc(BNE, 0, 1, 1, BR_T);
      // immediates
      cyc(ORI, 0, 1, 1, F_RDY);  cyc(ORI, 0, 1, 1, DEC);  cyc(ORI, 0, 1, 1, IEX_ORI);  cyc(ORI, 0, 1, 1, IWB);
      cyc(LUI, 0, 1, 1, F_RDY);  cyc(LUI, 0, 1, 1, DEC);  cyc(LUI, 0, 1, 1, IEX_LUI);  cyc(LUI, 0, 1, 1, IWB);
      cyc(ADDI, 0, 1, 1, F_RDY); cyc(ADDI, 0, 1, 1, DEC); cyc(ADDI, 0, 1, 1, IEX_ADD); cyc(ADDI, 0, 1, 1, IWB);
      // jump
      cyc(J, 0, 1, 1, F_RDY); cyc(J, 0, 1, 1, DEC); cyc(J, 0, 1, 1, JMP);
      // illegal opcode: single-cycle flag, back to fetch
      cyc(BAD, 0, 1, 1, F_RDY); cyc(BAD, 0, 1, 1, DEC_ILL); cyc(BAD, 0, 0, 1, F_WAIT);
      // SW stalled in MEM_WRITE, aborted by reset
      cyc(SW, 0, 1, 1, F_RDY); cyc(SW, 0, 1, 1, DEC); cyc(SW, 0, 1, 1, MADDR);
      cyc(SW, 0, 0, 1, MWR);   cyc(SW, 0, 0, 1, MWR);
      cyc(SW, 0, 0, 0, RST);   cyc(SW, 0, 0, 0, RST);
      cyc(R, 0, 1, 1, RST);
      cyc(R, 0, 1, 1, F_RDY);  cyc(R, 0, 1, 1, DEC); cyc(R, 0, 1, 1, R_EX); cyc(R, 0, 1, 1, R_WB);
      cyc(SW, 0, 1, 1, F_RDY); cyc(SW, 0, 1, 1, DEC); cyc(SW, 0, 1, 1, MADDR);
      cyc(SW, 0, 1, 1, MWR);   cyc(SW, 0, 0, 1, F_WAIT);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain left=%0d want=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multicycle main control unit. It sequences fetch, decode, execute, memory and writeback for the MIPS subset.
- Generates the 3-bit ALUOp consumed by the ALU control decoder, plus all datapath enables and mux selects.
- Drives the shared instruction/data memory through a ready handshake. Sits beside the register file, ALU and IR/MDR/A/B/ALUOut registers.

Parameters:
- STATE_W, 4, width of state register and dbg_state port.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; stable from the cycle after IRWrite.
- zero  in  1  ALU zero flag, valid in the cycle the ALU evaluates.
- mem_ready  in  1  memory completes the current read/write in this cycle.
- ALUOp  out  3  to ALU control.
- PCWrite  out  1  PC load enable, unconditional or branch-qualified.
- IorD  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR load enable.
- MemtoReg  out  1  writeback mux: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = extended imm, 11 = sign-ext imm<<2.
- ZeroExt  out  1  immediate extender: 1 = zero-extend, 0 = sign-extend.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- dbg_state  out  STATE_W  current state.

Behaviour:
- Opcodes: R 000000, ADDI 001000, ORI 001101, LUI 001111, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010.
- ALUOp codes:
  - 111 R-type.
  - 100 add: ADDI, LW/SW address, PC+4, branch target.
  - 101 or: ORI.
  - 000 lui: LUI.
  - 110 subtract: BEQ and BNE.
- Moore outputs decoded from state. Any output not listed for a state is 0, except ALUOp, which defaults to 100.
- Reset low: state = FETCH asynchronously. While reset is low, PCWrite, MemRead, MemWrite, IRWrite, RegWrite and illegal_op are forced 0. Released on the first clock after deassertion.
- FETCH (0):
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE (1): ALUSrcA=0, ALUSrcB=11 (branch target into ALUOut). Next state by opcode:
  - R → R_EXEC.
  - ADDI/ORI/LUI → I_EXEC.
  - LW/SW → MEM_ADDR.
  - BEQ/BNE → BRANCH.
  - J → JUMP.
  - Any other opcode → FETCH, with illegal_op=1 for this cycle.
- MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10. Next: LW → MEM_READ, SW → MEM_WRITE.
- MEM_READ (3): MemRead=1, IorD=1. Holds until mem_ready, then → MEM_WB.
- MEM_WB (4): RegWrite=1, MemtoReg=1, RegDst=0. Next → FETCH.
- MEM_WRITE (5): MemWrite=1, IorD=1. Holds until mem_ready, then → FETCH.
- R_EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=111. Next → R_WB.
- R_WB (7): RegWrite=1, RegDst=1. Next → FETCH.
- BRANCH (8):
  - ALUSrcA=1, ALUSrcB=00, ALUOp=110, PCSource=01.
  - PCWrite = (BEQ & zero) | (BNE & ~zero).
  - Next → FETCH.
- I_EXEC (9):
  - ALUSrcA=1, ALUSrcB=10.
  - ALUOp: ADDI → 100, ORI → 101, LUI → 000.
  - ZeroExt=1 for ORI only.
  - Next → I_WB.
- I_WB (10): RegWrite=1, RegDst=0, MemtoReg=0. Next → FETCH.
- JUMP (11): PCWrite=1, PCSource=10. Next → FETCH.
- Unused encodings 12–15: outputs at defaults; next state → FETCH.
- Reset asserted mid-operation (including MEM_WRITE awaiting ready) aborts immediately; MemWrite drops asynchronously.
- Latencies with mem_ready tied high: R/I-type 4 cycles, LW 5, SW 4, branch 3, J 3.

Test Plan:
- Release reset, mem_ready=1, opcode=000000 → dbg_state 0,1,6,7,0. ALUOp=111 in R_EXEC; RegWrite=1, RegDst=1 in R_WB.
- LW, mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_READ → FETCH held 3 cycles with IRWrite=0 until ready. MEM_READ held 4 cycles with MemRead=1, IorD=1. Then MEM_WB with MemtoReg=1.
- BEQ with zero=1 → PCWrite=1, PCSource=01 in BRANCH. BNE with zero=1 → PCWrite=0. BNE with zero=0 → PCWrite=1. ALUOp=110 in all three.
- ORI then LUI → I_EXEC shows ALUOp=101 with ZeroExt=1, then ALUOp=000 with ZeroExt=0. I_WB writes rt.
- SW, mem_ready=0, reset pulsed low in MEM_WRITE → MemWrite falls to 0 within the reset pulse, dbg_state=0, no register write.
- Opcode 111111 → DECODE asserts illegal_op for exactly 1 cycle; next state FETCH; no RegWrite, MemWrite or PCWrite.
